// File: rtl/pulse_gate_scheduler_if.sv
// Result port of pulse_gate_scheduler: one {channel, count, overflow} record per gate window.
interface pulse_gate_scheduler_if #(parameter int CNT_W = 16) ();
    // valid/ready: a record transfers on any clk_in edge where res_valid_out and res_ready_in
    // are both high; the producer holds valid high and the payload stable until that edge.
    logic             res_valid_out;
    logic             res_ready_in;
    logic [1:0]       res_chan_out;
    logic [CNT_W-1:0] res_count_out;
    logic             res_ovf_out;

    modport master (
        output res_valid_out, res_chan_out, res_count_out, res_ovf_out,
        input  res_ready_in
    );

    modport slave (
        input  res_valid_out, res_chan_out, res_count_out, res_ovf_out,
        output res_ready_in
    );
endinterface

// File: rtl/pulse_gate_scheduler.sv
// Round-robin gated edge counter shared by 4 pulse inputs; publishes one result per window.
// Optional macro PULSE_SYNC_EN inserts a 2-flop synchronizer in front of the edge detector.
module pulse_gate_scheduler #(
    parameter int GATE_CYCLES = 200_000_000,
    parameter int CNT_W       = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic                   stop_in,
    input  logic [3:0]             chan_mask_in,
    input  logic [3:0]             pulse_in,
    output logic                   busy_out,
    output logic [1:0]             dbg_state_out,
    pulse_gate_scheduler_if.master res
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_GATE    = 2'd2,
        S_PUBLISH = 2'd3
    } state_t;

    localparam int               TMR_W    = $clog2(GATE_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic             accept;
    logic [3:0]       pulse_s;
    logic [3:0]       prev_q;
    logic [3:0]       edge_det;
    logic [3:0]       mask_q;
    logic [1:0]       last_ch_q;
    logic [1:0]       cur_ch_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic [TMR_W-1:0] timer_q;
    logic             stop_pend_q;

`ifdef PULSE_SYNC_EN
    logic [3:0] sync1_q, sync2_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync1_q <= 4'b0;
            sync2_q <= 4'b0;
        end else begin
            sync1_q <= pulse_in;
            sync2_q <= sync1_q;
        end
    end

    assign pulse_s = sync2_q;
`else
    assign pulse_s = pulse_in;
`endif

    assign edge_det = pulse_s & ~prev_q;

    // Search starts just after the last published channel, so a lone channel picks itself again.
    function automatic logic [1:0] next_chan(input logic [3:0] mask, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        accept            = 1'b0;
        busy_out          = (state_q != S_IDLE);
        dbg_state_out     = state_q;
        res.res_valid_out = (state_q == S_PUBLISH);
        res.res_chan_out  = cur_ch_q;
        res.res_count_out = count_q;
        res.res_ovf_out   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start_in && (|chan_mask_in)) state_d = S_ARM;
            end
            S_ARM: begin
                state_d = S_GATE;
            end
            S_GATE: begin
                if (timer_q == TMR_LAST) state_d = S_PUBLISH;
            end
            S_PUBLISH: begin
                if (res.res_ready_in) begin
                    accept  = 1'b1;
                    // A stop arriving on the accepting cycle still ends the scan here.
                    state_d = (stop_pend_q || stop_in) ? S_IDLE : S_ARM;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prev_q      <= 4'b0;
            mask_q      <= 4'b0;
            last_ch_q   <= 2'd3;
            cur_ch_q    <= 2'd0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            timer_q     <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            prev_q <= pulse_s;
            case (state_q)
                S_IDLE: begin
                    if (start_in && (|chan_mask_in)) mask_q <= chan_mask_in;
                end
                S_ARM: begin
                    cur_ch_q <= next_chan(mask_q, last_ch_q);
                    count_q  <= '0;
                    ovf_q    <= 1'b0;
                    timer_q  <= '0;
                end
                S_GATE: begin
                    timer_q <= timer_q + TMR_W'(1);
                    if (edge_det[cur_ch_q]) begin
                        if (count_q == CNT_MAX) ovf_q <= 1'b1;
                        else                    count_q <= count_q + CNT_W'(1);
                    end
                end
                S_PUBLISH: begin
                    if (accept) last_ch_q <= cur_ch_q;
                end
                default: ;
            endcase
            if (state_q != S_IDLE && state_d == S_IDLE) stop_pend_q <= 1'b0;
            else if (state_q != S_IDLE && stop_in)      stop_pend_q <= 1'b1;
        end
    end

endmodule
